// File: rtl/axis_quad_tracker_pkg.sv
// Shared encodings for axis_quad_tracker: channel hysteresis states, decode
// directions and the Gray-code transition constants used by the position decoder.
package axis_quad_tracker_pkg;

  typedef enum logic [1:0] {
    CH_UNKNOWN = 2'b00,
    CH_LOW     = 2'b01,
    CH_HIGH    = 2'b10
  } chan_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_FWD  = 2'b01,
    DIR_REV  = 2'b10,
    DIR_ERR  = 2'b11
  } quad_dir_t;

  // {prev_ab, next_ab} with ab = {A is HIGH, B is HIGH}
  localparam logic [3:0] GRAY_FWD_00_10 = 4'b00_10;
  localparam logic [3:0] GRAY_FWD_10_11 = 4'b10_11;
  localparam logic [3:0] GRAY_FWD_11_01 = 4'b11_01;
  localparam logic [3:0] GRAY_FWD_01_00 = 4'b01_00;
  localparam logic [3:0] GRAY_REV_10_00 = 4'b10_00;
  localparam logic [3:0] GRAY_REV_11_10 = 4'b11_10;
  localparam logic [3:0] GRAY_REV_01_11 = 4'b01_11;
  localparam logic [3:0] GRAY_REV_00_01 = 4'b00_01;

  function automatic quad_dir_t gray_dir(input logic [1:0] prev_ab, input logic [1:0] next_ab);
    quad_dir_t dir;
    case ({prev_ab, next_ab})
      GRAY_FWD_00_10, GRAY_FWD_10_11, GRAY_FWD_11_01, GRAY_FWD_01_00: dir = DIR_FWD;
      GRAY_REV_10_00, GRAY_REV_11_10, GRAY_REV_01_11, GRAY_REV_00_01: dir = DIR_REV;
      default: begin
        if ((prev_ab ^ next_ab) == 2'b11) begin
          dir = DIR_ERR;
        end else begin
          dir = DIR_NONE;
        end
      end
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/axis_quad_tracker_channel.sv
// hysteresis_channel: one UNKNOWN/LOW/HIGH hysteresis state machine fed by
// accepted samples; the upper threshold check wins if both would fire.
module hysteresis_channel
  import axis_quad_tracker_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                sample_valid,
  input  logic signed [W-1:0] sample,
  input  logic signed [W-1:0] lower_threshold,
  input  logic signed [W-1:0] upper_threshold,
  output logic [1:0]          state
);

  chan_state_t state_r;
  chan_state_t state_next_s;

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= CH_UNKNOWN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Strict threshold compares; equality holds the current state
  always_comb begin
    state_next_s = state_r;
    if (sample_valid && (sample > upper_threshold)) begin
      state_next_s = CH_HIGH;
    end else if (sample_valid && (sample < lower_threshold)) begin
      state_next_s = CH_LOW;
    end else begin
      state_next_s = state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/axis_quad_tracker.sv
// axis_quad_tracker: two-channel hysteresis quadrature decoder with an AXI-Stream
// position output. Optional error counter enabled by AXIS_QUAD_TRACKER_ERRCNT_EN.
module axis_quad_tracker
  import axis_quad_tracker_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH      = 16
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
  input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
  input  logic [4:0]                             log_scale,
  input  logic                                   clear,
  input  logic                                   S_AXIS_tvalid,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_tdata,
  output logic                                   S_AXIS_tready,
  input  logic                                   M_AXIS_tready,
  output logic                                   M_AXIS_tvalid,
  output logic [M_AXIS_TDATA_WIDTH-1:0]          M_AXIS_tdata,
  output logic [ERR_CNT_WIDTH-1:0]               error_count
);

  localparam int H = S_AXIS_TDATA_WIDTH / 2;
  localparam int M = M_AXIS_TDATA_WIDTH;

  logic [1:0]  state_a_s;
  logic [1:0]  state_b_s;
  chan_state_t cur_a_s;
  chan_state_t cur_b_s;
  chan_state_t prev_a_r;
  chan_state_t prev_b_r;
  quad_dir_t   dir_s;
  logic [M-1:0] step_s;
  logic [M-1:0] pos_r;
  logic [M-1:0] pos_next_s;
  logic         pos_upd_s;
  logic         tvalid_r;
  logic         tvalid_next_s;

  assign S_AXIS_tready = 1'b1;

  hysteresis_channel #(.W(H)) u_chan_a (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .sample_valid    (S_AXIS_tvalid),
    .sample          (S_AXIS_tdata[H-1:0]),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .state           (state_a_s)
  );

  hysteresis_channel #(.W(H)) u_chan_b (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .sample_valid    (S_AXIS_tvalid),
    .sample          (S_AXIS_tdata[S_AXIS_TDATA_WIDTH-1:H]),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .state           (state_b_s)
  );

  assign cur_a_s = chan_state_t'(state_a_s);
  assign cur_b_s = chan_state_t'(state_b_s);

  // Snapshot of channel states one edge behind, so a change is decoded an edge later
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      prev_a_r <= CH_UNKNOWN;
      prev_b_r <= CH_UNKNOWN;
    end else begin
      prev_a_r <= cur_a_s;
      prev_b_r <= cur_b_s;
    end
  end

  // Quadrature decode, inhibited while any side of the transition is UNKNOWN
  always_comb begin
    dir_s = DIR_NONE;
    if ((prev_a_r == CH_UNKNOWN) || (prev_b_r == CH_UNKNOWN) ||
        (cur_a_s == CH_UNKNOWN) || (cur_b_s == CH_UNKNOWN)) begin
      dir_s = DIR_NONE;
    end else begin
      dir_s = gray_dir({prev_a_r == CH_HIGH, prev_b_r == CH_HIGH},
                       {cur_a_s == CH_HIGH, cur_b_s == CH_HIGH});
    end
  end

  // Step size; shifts at or beyond the output width give a zero step
  always_comb begin
    step_s = {M{1'b0}};
    if (32'(log_scale) < M) begin
      step_s = {{(M-1){1'b0}}, 1'b1} << log_scale;
    end else begin
      step_s = {M{1'b0}};
    end
  end

  // Next position and output-valid; clear beats a simultaneous step
  always_comb begin
    pos_next_s    = pos_r;
    pos_upd_s     = 1'b0;
    tvalid_next_s = tvalid_r;
    if (clear) begin
      pos_next_s = {M{1'b0}};
      pos_upd_s  = 1'b1;
    end else begin
      case (dir_s)
        DIR_FWD: begin
          pos_next_s = pos_r + step_s;
          pos_upd_s  = 1'b1;
        end
        DIR_REV: begin
          pos_next_s = pos_r - step_s;
          pos_upd_s  = 1'b1;
        end
        default: begin
          pos_next_s = pos_r;
          pos_upd_s  = 1'b0;
        end
      endcase
    end
    if (pos_upd_s) begin
      tvalid_next_s = 1'b1;
    end else if (M_AXIS_tready) begin
      tvalid_next_s = 1'b0;
    end else begin
      tvalid_next_s = tvalid_r;
    end
  end

  // Position and output-valid registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pos_r    <= {M{1'b0}};
      tvalid_r <= 1'b0;
    end else begin
      pos_r    <= pos_next_s;
      tvalid_r <= tvalid_next_s;
    end
  end

  assign M_AXIS_tdata  = pos_r;
  assign M_AXIS_tvalid = tvalid_r;

`ifdef AXIS_QUAD_TRACKER_ERRCNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

  // Saturating count of both-bits-changed transitions
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_cnt_r <= {ERR_CNT_WIDTH{1'b0}};
    end else if ((dir_s == DIR_ERR) && (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign error_count = err_cnt_r;
`else
  assign error_count = {ERR_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_axis_quad_tracker.sv
// Directed bench for axis_quad_tracker: stimulus pushes expected positions into a
// scoreboard queue, a negedge monitor pops one per output handshake.
module tb_axis_quad_tracker;

  logic               aclk;
  logic               aresetn;
  logic signed [15:0] lower_threshold;
  logic signed [15:0] upper_threshold;
  logic [4:0]         log_scale;
  logic               clear;
  logic               S_AXIS_tvalid;
  logic [31:0]        S_AXIS_tdata;
  logic               S_AXIS_tready;
  logic               M_AXIS_tready;
  logic               M_AXIS_tvalid;
  logic [31:0]        M_AXIS_tdata;
  logic [15:0]        error_count;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];

  axis_quad_tracker dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .log_scale       (log_scale),
    .clear           (clear),
    .S_AXIS_tvalid   (S_AXIS_tvalid),
    .S_AXIS_tdata    (S_AXIS_tdata),
    .S_AXIS_tready   (S_AXIS_tready),
    .M_AXIS_tready   (M_AXIS_tready),
    .M_AXIS_tvalid   (M_AXIS_tvalid),
    .M_AXIS_tdata    (M_AXIS_tdata),
    .error_count     (error_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic beat(input logic signed [15:0] a, input logic signed [15:0] b);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = {b, a};
    tick();
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = 32'h8000_8000;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest expected position
  always @(negedge aclk) begin
    if (aresetn && M_AXIS_tvalid && M_AXIS_tready) begin
      if (exp_q.size() == 0) begin
        tests_run    = tests_run + 1;
        tests_failed = tests_failed + 1;
        $display("FAIL unexpected_output: got 0x%08h expected no transfer", M_AXIS_tdata);
      end else begin
        check("scoreboard_tdata", M_AXIS_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_err;
`ifdef AXIS_QUAD_TRACKER_ERRCNT_EN
    exp_err = 16'd1;
`else
    exp_err = 16'd0;
`endif
    tests_run       = 0;
    tests_failed    = 0;
    aresetn         = 1'b0;
    lower_threshold = -16'sd1000;
    upper_threshold = 16'sd1000;
    log_scale       = 5'd0;
    clear           = 1'b0;
    S_AXIS_tvalid   = 1'b0;
    S_AXIS_tdata    = 32'h8000_8000;
    M_AXIS_tready   = 1'b1;
    idle(2);
    check("reset_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    check("reset_tdata", M_AXIS_tdata, 32'd0);
    check("reset_err", {16'd0, error_count}, 32'd0);
    check("s_tready", {31'd0, S_AXIS_tready}, 32'd1);
    aresetn = 1'b1;
    idle(1);

    // Forward: first transition out of UNKNOWN is not counted
    beat(-16'sd2000, -16'sd2000);
    exp_q.push_back(32'd1); beat(16'sd2000, -16'sd2000);
    exp_q.push_back(32'd2); beat(16'sd2000, 16'sd2000);
    exp_q.push_back(32'd3); beat(-16'sd2000, 16'sd2000);
    exp_q.push_back(32'd4); beat(-16'sd2000, -16'sd2000);
    idle(3);

    // Reverse from zero
    exp_q.push_back(32'd0); pulse_clear();
    idle(2);
    exp_q.push_back(32'hFFFF_FFFF); beat(-16'sd2000, 16'sd2000);
    exp_q.push_back(32'hFFFF_FFFE); beat(16'sd2000, 16'sd2000);
    exp_q.push_back(32'hFFFF_FFFD); beat(16'sd2000, -16'sd2000);
    exp_q.push_back(32'hFFFF_FFFC); beat(-16'sd2000, -16'sd2000);
    idle(3);

    // Inside the hysteresis band and at the thresholds: no change
    beat(-16'sd999, -16'sd2000);
    beat(16'sd999, -16'sd2000);
    beat(16'sd1000, -16'sd1000);
    beat(-16'sd999, -16'sd2000);
    idle(3);
    check("hyst_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    check("hyst_tdata", M_AXIS_tdata, 32'hFFFF_FFFC);

    // Both channels flip in one beat
    beat(16'sd2000, 16'sd2000);
    idle(3);
    check("illegal_err", {16'd0, error_count}, {16'd0, exp_err});
    check("illegal_tdata", M_AXIS_tdata, 32'hFFFF_FFFC);
    check("illegal_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);

    // Large steps wrap; log_scale=2 steps by 4
    exp_q.push_back(32'd0); pulse_clear();
    idle(2);
    log_scale = 5'd31;
    exp_q.push_back(32'h8000_0000); beat(-16'sd2000, 16'sd2000);
    exp_q.push_back(32'h0000_0000); beat(-16'sd2000, -16'sd2000);
    idle(2);
    log_scale = 5'd2;
    exp_q.push_back(32'd4); beat(16'sd2000, -16'sd2000);
    idle(2);
    log_scale = 5'd0;

    // Backpressure: latest value wins
    exp_q.push_back(32'd0); pulse_clear();
    idle(2);
    M_AXIS_tready = 1'b0;
    beat(16'sd2000, 16'sd2000);
    beat(-16'sd2000, 16'sd2000);
    beat(-16'sd2000, -16'sd2000);
    idle(2);
    check("bp_tvalid", {31'd0, M_AXIS_tvalid}, 32'd1);
    check("bp_tdata", M_AXIS_tdata, 32'd3);
    exp_q.push_back(32'd3);
    M_AXIS_tready = 1'b1;
    tick();
    check("bp_tvalid_drop", {31'd0, M_AXIS_tvalid}, 32'd0);

    // Clear on the same edge as a step
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = {-16'sd2000, 16'sd2000};
    tick();
    S_AXIS_tvalid = 1'b0;
    exp_q.push_back(32'd0);
    pulse_clear();
    idle(2);
    check("clear_step_tdata", M_AXIS_tdata, 32'd0);

    // Reset mid-sequence discards a pending output and restarts decode
    M_AXIS_tready = 1'b0;
    beat(16'sd2000, 16'sd2000);
    idle(2);
    check("pre_reset_tvalid", {31'd0, M_AXIS_tvalid}, 32'd1);
    aresetn = 1'b0;
    tick();
    check("mid_reset_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    check("mid_reset_tdata", M_AXIS_tdata, 32'd0);
    check("mid_reset_err", {16'd0, error_count}, 32'd0);
    aresetn = 1'b1;
    M_AXIS_tready = 1'b1;
    beat(-16'sd2000, 16'sd2000);
    idle(3);
    check("post_reset_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
    check("post_reset_tdata", M_AXIS_tdata, 32'd0);
    exp_q.push_back(32'd1); beat(-16'sd2000, -16'sd2000);
    idle(4);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
